config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Upstream sequencer for the configuration latch bank.
- Accepts a stream of 32-bit configuration words over a valid/ready handshake.
- Drives the shared data bus `io_d_out` and a one-hot, registered, glitch-free latch-enable vector `io_configs_en` that writes each word into its slot in order.
- Data is held stable before, during and after each enable pulse, giving the transparent latches clean setup/hold margin; reports busy/done to the tile config controller.

Parameters:
- WORD_W, 32, width of one configuration word / latch slot.
- NUM_WORDS, 20, number of latch slots (640 config bits total).
- IDX_W, 5, width of the slot index; must satisfy 2^IDX_W >= NUM_WORDS.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- io_start  input  1  begin a full load; honoured only in IDLE or DONE.
- io_in_valid  input  1  config word valid.
- io_in_ready  output  1  loader can accept a word.
- io_in_bits  input  WORD_W  config word.
- io_d_out  output  WORD_W  data bus to latch bank `io_d_in`.
- io_configs_en  output  NUM_WORDS  one-hot latch enables to latch bank `io_configs_en`.
- io_busy  output  1  load in progress (state not IDLE/DONE).
- io_done  output  1  all NUM_WORDS slots written; held until next start or reset.
- io_word_idx  output  IDX_W  slot currently being loaded.

Behaviour:
- Clock and reset: clk single clock; reset synchronous, active-high. All state updates on rising clk.
- Reset values: state=IDLE, io_d_out=0, io_configs_en=0, io_in_ready=0, io_busy=0, io_done=0, io_word_idx=0.
- States: IDLE, WAIT, SETUP, STROBE, HOLD, DONE.
- IDLE/DONE:
  - io_start=1 -> WAIT, idx=0, done=0.
  - io_in_valid is ignored and ready=0.
- WAIT:
  - io_in_ready=1 (decoded from registered state only).
  - valid&&ready -> capture io_in_bits into the d_out register, go to SETUP.
  - valid low -> stay in WAIT, en stays 0, no timeout.
- SETUP: en=0, d_out stable; next state STROBE.
- STROBE: io_configs_en[idx]=1 for exactly one cycle, all other bits 0.
- HOLD:
  - en=0, d_out unchanged.
  - If idx==NUM_WORDS-1 -> DONE with done=1.
  - Otherwise idx+1 -> WAIT.
- Timing:
  - Handshake in cycle c0 -> SETUP c1, en pulse c2, HOLD c3, ready or done in c4.
  - Minimum 4 cycles per word; full load takes at least 4*NUM_WORDS cycles.
- Output registration:
  - io_configs_en is driven directly from flops: no combinational decode on the output, no glitches.
  - Never more than one bit high at once.
- io_d_out changes only on a handshake. It is held through SETUP, STROBE, HOLD and the following WAIT, and holds the last word in DONE.
- io_start while busy is ignored; io_start in DONE restarts the load.
- Reset mid-operation (any state, including STROBE):
  - Next cycle en=0 and all outputs take their reset values.
  - Latch bank contents are not cleared by this block.
- io_word_idx never exceeds NUM_WORDS-1; there is no wrap-around, and the counter freezes in DONE.
- Simultaneous io_start and io_in_valid in IDLE: start is taken; the word is not accepted that cycle (ready=0).

Decomposition:
- Shared package config_pkg holds:
  - WORD_W, NUM_WORDS, IDX_W constants;
  - the loader state enum;
  - a function computing the one-hot from the index.
- One sub-module, config_en_decoder: a registered index-to-one-hot decoder with a strobe input and synchronous reset.
- The FSM, index counter and data register stay in config_loader.

Test Plan:
- Full load: start, then words 0x1000_0000+i for i=0..19 with valid held high:
  - en[i] pulses exactly once, in order, 4 cycles apart;
  - d_out equals the word in the SETUP, STROBE and HOLD cycles;
  - done=1 four cycles after the last handshake;
  - a scoreboard latch model holds all 20 words.
- Backpressure gaps: drop valid for 0–7 random cycles between words:
  - stays in WAIT with en=0 and d_out unchanged;
  - final contents are identical to the full-load case.
- Start/valid while busy: pulse io_start at word 5 and drive valid in SETUP/STROBE/HOLD:
  - no restart, no extra word consumed;
  - idx progresses 5->6 normally.
- Reset at STROBE of word 7:
  - next cycle en=0, idx=0, busy=0, done=0, ready=0, d_out=0;
  - a subsequent start reloads from slot 0.
- Restart after done: second start with words 0xA5A5_0000+i:
  - done drops the cycle after start;
  - all slots are rewritten; done reasserts.
- IDLE guard: valid=1 with 0xDEAD_BEEF, no start, for 10 cycles:
  - ready=0, en=0, d_out=0, nothing accepted.

Source files
------------

// File: rtl/config_pkg.sv
// Shared constants, loader state encoding and slot-enable helper for the
// configuration latch-bank loader.
package config_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 20;
  localparam int IDX_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } loader_state_e;

  // One-hot slot enable for a given slot index; out-of-range indices give all zeros.
  function automatic logic [NUM_WORDS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_WORDS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == IDX_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/config_en_decoder.sv
// Registered index-to-one-hot decoder. The enable vector comes straight from
// flops so the latch bank never sees decode glitches; it is high only in the
// cycle after i_strobe.
module config_en_decoder
  import config_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_strobe,
  input  logic [IDX_W-1:0]     i_idx,
  output logic [NUM_WORDS-1:0] o_en
);

  logic [NUM_WORDS-1:0] r_en;

  // Load the one-hot for the current slot on strobe, otherwise clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en <= '0;
    end else if (i_strobe) begin
      r_en <= idx_to_onehot(i_idx);
    end else begin
      r_en <= '0;
    end
  end

  assign o_en = r_en;

endmodule

// File: rtl/config_loader.sv
// Configuration latch-bank loader: accepts words over valid/ready and writes
// each into its slot with a setup / strobe / hold sequence on the shared bus.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no load in progress, waiting for io_start
// ST_WAIT   | ready high, waiting for the next word of the current load
// ST_SETUP  | word on io_d_out, enables low (latch setup margin)
// ST_STROBE | enable for the current slot high for one cycle
// ST_HOLD   | enables low, data held (latch hold margin); advance slot
// ST_DONE   | all slots written, last word held on the bus
module config_loader
  import config_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic [IDX_W-1:0]     io_word_idx
);

  loader_state_e     r_state;
  loader_state_e     w_state_next;
  logic [WORD_W-1:0] r_d_out;
  logic [IDX_W-1:0]  r_idx;

  logic w_idle_or_done;
  logic w_start_ok;
  logic w_handshake;
  logic w_last;
  logic w_strobe;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_ok     = io_start && w_idle_or_done;
  assign w_handshake    = io_in_valid && (r_state == ST_WAIT);
  assign w_last         = (r_idx == IDX_W'(NUM_WORDS - 1));
  // Arm the decoder in SETUP so its flops are high exactly during STROBE.
  assign w_strobe       = (r_state == ST_SETUP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured when no load is running.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok)  w_state_next = ST_WAIT;
      ST_WAIT:   if (w_handshake) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_STROBE;
      ST_STROBE: w_state_next = ST_HOLD;
      ST_HOLD:   w_state_next = w_last ? ST_DONE : ST_WAIT;
      ST_DONE:   if (w_start_ok)  w_state_next = ST_WAIT;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Data bus register: changes only on an accepted word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_out <= '0;
    end else if (w_handshake) begin
      r_d_out <= io_in_bits;
    end
  end

  // Slot index: cleared on start, advanced at the end of HOLD, frozen on the last slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_start_ok) begin
      r_idx <= '0;
    end else if ((r_state == ST_HOLD) && !w_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  config_en_decoder u_en_decoder (
    .clk      (clk),
    .reset    (reset),
    .i_strobe (w_strobe),
    .i_idx    (r_idx),
    .o_en     (io_configs_en)
  );

  assign io_in_ready = (r_state == ST_WAIT);
  assign io_busy     = !w_idle_or_done;
  assign io_done     = (r_state == ST_DONE);
  assign io_d_out    = r_d_out;
  assign io_word_idx = r_idx;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: transaction-level reference model,
// per-cycle output compare, latch-bank scoreboard and literal spot checks.
module tb_config_loader;
  import config_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 io_start = 1'b0;
  logic                 io_in_valid = 1'b0;
  logic [WORD_W-1:0]    io_in_bits = '0;
  logic                 io_in_ready;
  logic [WORD_W-1:0]    io_d_out;
  logic [NUM_WORDS-1:0] io_configs_en;
  logic                 io_busy;
  logic                 io_done;
  logic [IDX_W-1:0]     io_word_idx;

  config_loader dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_bits    (io_in_bits),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_word_idx   (io_word_idx)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Reference model: a load is "active" between start and the final slot;
  // m_age counts cycles since the last accepted word (-1 = waiting for one).
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_idx    = 0;
  int          m_age    = -1;
  logic [31:0] m_dout   = '0;

  logic [31:0] dut_latch [NUM_WORDS];
  int          pulse_cnt [NUM_WORDS];
  logic [NUM_WORDS-1:0] exp_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model update on each rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_active <= 1'b0; m_done <= 1'b0; m_idx <= 0; m_dout <= '0; m_age <= -1;
    end else if (!m_active) begin
      if (io_start) begin
        m_active <= 1'b1; m_done <= 1'b0; m_idx <= 0; m_age <= -1;
      end
    end else if (m_age < 0) begin
      if (io_in_valid) begin
        m_dout <= io_in_bits; m_age <= 1;
      end
    end else if (m_age < 3) begin
      m_age <= m_age + 1;
    end else begin
      m_age <= -1;
      if (m_idx == NUM_WORDS - 1) begin
        m_active <= 1'b0; m_done <= 1'b1;
      end else begin
        m_idx <= m_idx + 1;
      end
    end
  end

  // Per-cycle compare on the falling edge, plus latch-bank observation.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_en = (m_active && m_age == 2) ? (NUM_WORDS'(1) << m_idx) : '0;
      check("cycle_outputs",
            {io_in_ready, io_busy, io_done, io_word_idx, io_configs_en, io_d_out},
            {(m_active && m_age < 0), m_active, m_done, IDX_W'(m_idx), exp_en, m_dout});
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (io_configs_en[i]) begin
          dut_latch[i] = io_d_out;
          pulse_cnt[i]++;
        end
      end
    end
  end

  task automatic start_pulse();
    io_start = 1'b1;
    @(posedge clk); #1;
    io_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int budget;
    for (int g = 0; g < gap; g++) begin
      io_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    io_in_valid = 1'b1;
    io_in_bits  = w;
    budget = 0;
    while (!io_in_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!io_in_ready) begin
      asserts++; fails++;
      $display("FAIL handshake_timeout: ready=0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!io_done && edges < 400) begin
      @(posedge clk); #1;
      edges++;
    end
    io_in_valid = 1'b0;
    check("done_reached", io_done, 1);
  endtask

  task automatic check_bank(input logic [31:0] base);
    for (int i = 0; i < NUM_WORDS; i++) begin
      check($sformatf("bank_slot%0d", i), {pulse_cnt[i], dut_latch[i]}, {32'd1, base + 32'(i)});
    end
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < NUM_WORDS; i++) pulse_cnt[i] = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {io_in_ready, io_busy, io_done, io_word_idx, io_configs_en, io_d_out}, 64'd0);
  endtask

  initial begin
    int s, n;
    for (int i = 0; i < NUM_WORDS; i++) begin
      dut_latch[i] = '0;
      pulse_cnt[i] = 0;
    end

    // Reset.
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_reset_outputs("reset_values");
    reset = 1'b0;

    // Valid without start is ignored in IDLE.
    io_in_valid = 1'b1;
    io_in_bits  = 32'hDEAD_BEEF;
    repeat (10) begin
      @(posedge clk); #1;
      check("idle_guard", {io_in_ready, io_configs_en, io_d_out}, 64'd0);
    end
    io_in_valid = 1'b0;
    check("idle_guard_busy", io_busy, 0);

    // Full load, valid held high: done 80 edges after the start edge.
    io_start = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    io_start = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) send_word(32'h1000_0000 + 32'(i), 0);
    wait_done(n);
    check("done_latency", 64'(cyc - s), 64'd80);
    check_bank(32'h1000_0000);
    clear_pulses();

    // Restart from DONE with random gaps and start/valid while busy at word 5.
    start_pulse();
    check("restart_done_drops", {io_done, io_busy, io_word_idx}, {1'b0, 1'b1, 5'd0});
    for (int i = 0; i < NUM_WORDS; i++) begin
      send_word(32'h1000_0000 + 32'(i), int'($urandom_range(0, 7)));
      if (i == 5) begin
        io_start = 1'b1;
        io_in_bits = 32'hBAD0_0005;
        repeat (3) begin @(posedge clk); #1; end
        io_start = 1'b0;
        check("idx_after_busy_start", io_word_idx, 6);
      end
    end
    wait_done(n);
    check_bank(32'h1000_0000);
    clear_pulses();

    // Restart with a second word set.
    start_pulse();
    check("restart2_done_drops", io_done, 0);
    for (int i = 0; i < NUM_WORDS; i++) send_word(32'hA5A5_0000 + 32'(i), int'($urandom_range(0, 7)));
    wait_done(n);
    check_bank(32'hA5A5_0000);
    clear_pulses();

    // Reset while strobing word 7, then reload from slot 0.
    start_pulse();
    for (int i = 0; i < 8; i++) send_word(32'h3000_0000 + 32'(i), int'($urandom_range(0, 3)));
    @(posedge clk); #1;
    check("strobe_word7", io_configs_en, 64'h80);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_strobe");
    reset = 1'b0;
    io_in_valid = 1'b0;
    clear_pulses();
    @(posedge clk); #1;
    start_pulse();
    check("reload_idx0", {io_busy, io_word_idx}, {1'b1, 5'd0});
    for (int i = 0; i < NUM_WORDS; i++) send_word(32'h1000_0000 + 32'(i), 0);
    wait_done(n);
    check_bank(32'h1000_0000);

    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
